// File: rtl/ecg_frame_windower.sv
// ecg_frame_windower: assembles a sliding N-sample window from a valid/ready
// sample stream, holds it stable for SETTLE cycles while the downstream CNN
// settles, captures the CNN class vector, then slides the window by HOP.
module ecg_frame_windower #(
  parameter int N      = 32,
  parameter int W      = 16,
  parameter int HOP    = 8,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           s_valid,
  input  logic [W-1:0]   s_data,
  output logic           s_ready,
  output logic [N*W-1:0] frame_out,
  output logic           frame_valid,
  input  logic [7:0]     class_in,
  output logic [7:0]     class_out,
  output logic           class_valid,
  output logic [15:0]    frame_count
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOP     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] settle_q, settle_d;
  logic [CW-1:0] hop_q, hop_d;
  logic [7:0]    class_q, class_d;
  logic          cvalid_q, cvalid_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic [W-1:0]  win_q [N];
  logic          accept_s;
  logic          shift_s;

  // Ready depends on state only, so upstream never sees a valid->ready loop.
  assign s_ready     = (state_q == ST_FILL) || (state_q == ST_HOP);
  assign accept_s    = s_valid & s_ready;
  assign frame_valid = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign class_out   = class_q;
  assign class_valid = cvalid_q;
  assign frame_count = fcnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pack
      assign frame_out[gi*W +: W] = win_q[gi];
    end
  endgenerate

  // Next-state, counter and capture logic; flush overrides any accept.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    settle_d = settle_q;
    hop_d    = hop_q;
    class_d  = class_q;
    cvalid_d = 1'b0;
    fcnt_d   = fcnt_q;
    shift_s  = 1'b0;
    if (flush) begin
      state_d  = ST_FILL;
      fill_d   = '0;
      settle_d = '0;
      hop_d    = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept_s) begin
            shift_s = 1'b1;
            if (fill_q == CW'(N - 1)) begin
              state_d  = ST_SETTLE;
              fill_d   = '0;
              settle_d = '0;
            end else begin
              fill_d = fill_q + CW'(1);
            end
          end else begin
            fill_d = fill_q;
          end
        end
        ST_SETTLE: begin
          if (settle_q == CW'(SETTLE - 1)) begin
            state_d  = ST_CAPTURE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + CW'(1);
          end
        end
        ST_CAPTURE: begin
          class_d  = class_in;
          cvalid_d = 1'b1;
          fcnt_d   = fcnt_q + 16'd1;
          state_d  = ST_HOP;
          hop_d    = '0;
        end
        ST_HOP: begin
          if (accept_s) begin
            shift_s = 1'b1;
            if (hop_q == CW'(HOP - 1)) begin
              state_d  = ST_SETTLE;
              hop_d    = '0;
              settle_d = '0;
            end else begin
              hop_d = hop_q + CW'(1);
            end
          end else begin
            hop_d = hop_q;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  // State, counters and registered class outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      fill_q   <= '0;
      settle_q <= '0;
      hop_q    <= '0;
      class_q  <= 8'd0;
      cvalid_q <= 1'b0;
      fcnt_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      settle_q <= settle_d;
      hop_q    <= hop_d;
      class_q  <= class_d;
      cvalid_q <= cvalid_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Sample window: shifts toward index 0 on each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
    end else if (shift_s) begin
      for (int i = 0; i < N - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[N-1] <= s_data;
    end else begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= win_q[i];
      end
    end
  end

endmodule

// File: tb/tb_ecg_frame_windower.sv
// Testbench for ecg_frame_windower: table-driven window rows plus flush and
// asynchronous-reset sequences, with a scoreboard of expected class captures.
module tb_ecg_frame_windower;
  localparam int N = 32, W = 16, HOP = 8, SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           s_valid = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           s_ready;
  logic [N*W-1:0] frame_out;
  logic           frame_valid;
  logic [7:0]     class_in = 8'd0;
  logic [7:0]     class_out;
  logic           class_valid;
  logic [15:0]    frame_count;

  ecg_frame_windower #(.N(N), .W(W), .HOP(HOP), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .frame_out(frame_out), .frame_valid(frame_valid),
    .class_in(class_in), .class_out(class_out), .class_valid(class_valid),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]     cls;
    logic [15:0]    fc;
    logic [N*W-1:0] frame;
    int             cyc;
  } exp_t;

  typedef struct {
    int         n;
    logic [W-1:0] first;
    logic [7:0] cls;
    bit         gaps;
    bit         hold_next;
    int         stall_exp;
    logic [W-1:0] exp_s0;
    logic [W-1:0] exp_s31;
  } row_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [W-1:0] mwin [N];
  int          need;
  logic [15:0] fc_model;
  logic [7:0]  cur_cls;
  int          last_stall;
  row_t        rows [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack_model();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = mwin[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mwin[i] = '0;
    need = N;
    fc_model = 16'd0;
  endtask

  // Offer one sample (optionally with flush) and wait for it to be taken.
  task automatic send(input logic [W-1:0] d, input bit gaps, input bit with_flush);
    int waitc;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(1, 0)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    flush   = with_flush;
    waitc   = 0;
    while (!s_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    last_stall = waitc;
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got s_ready=0 want 1 within 20 cycles");
      flush = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      if (with_flush) begin
        need = N;
      end else begin
        for (int i = 0; i < N - 1; i++) mwin[i] = mwin[i+1];
        mwin[N-1] = d;
        need--;
        if (need == 0) begin
          fc_model = fc_model + 16'd1;
          sb.push_back('{cls: cur_cls, fc: fc_model, frame: pack_model(), cyc: cyc});
          need = HOP;
        end
      end
    end
  endtask

  task automatic do_flush();
    s_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    need = N;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL class_timeout: got no class_valid want pulse within 50 cycles");
      sb.delete();
    end
  endtask

  task automatic run_row(input row_t rw);
    for (int i = 0; i < rw.n; i++) begin
      send(rw.first + W'(i), rw.gaps, 1'b0);
      if (i == 0) begin
        if (rw.stall_exp >= 0) check("hop_stall_cycles", 64'(last_stall), 64'(rw.stall_exp));
        class_in = rw.cls;
        cur_cls  = rw.cls;
      end
    end
    check("s_ready_after_window", 64'(s_ready), 64'd0);
    check("frame_valid_after_window", 64'(frame_valid), 64'd1);
    check("sample0", 64'(frame_out[W-1:0]), 64'(rw.exp_s0));
    check("sample_last", 64'(frame_out[N*W-1 -: W]), 64'(rw.exp_s31));
    if (!rw.hold_next) begin
      s_valid = 1'b0;
      wait_done();
      check("class_out_row", 64'(class_out), 64'(rw.cls));
      check("frame_count_row", 64'(frame_count), 64'(fc_model));
    end
  endtask

  // Scoreboard consumer: every class_valid pulse must match a pending window.
  always @(negedge clk) begin
    if (!rst && class_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_class_valid: got 1 want 0");
      end else begin
        mon_e = sb.pop_front();
        check("sb_class_out", 64'(class_out), 64'(mon_e.cls));
        check("sb_frame_count", 64'(frame_count), 64'(mon_e.fc));
        check_frame("sb_frame", frame_out, mon_e.frame);
        check("sb_latency", 64'(cyc), 64'(mon_e.cyc + SETTLE + 1));
      end
    end
  end

  initial begin
    rows[0] = '{32, 16'd1,  8'hA5, 1'b0, 1'b1, -1, 16'd1,  16'd32};
    rows[1] = '{8,  16'd33, 8'h3C, 1'b0, 1'b0,  3, 16'd9,  16'd40};
    rows[2] = '{8,  16'd41, 8'h5A, 1'b1, 1'b0, -1, 16'd17, 16'd48};
    rows[3] = '{32, 16'd1,  8'hA5, 1'b1, 1'b0, -1, 16'd1,  16'd32};
    model_reset();
    cur_cls = 8'd0;

    repeat (2) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_frame_valid", 64'(frame_valid), 64'd0);
    check("rst_class_out", 64'(class_out), 64'd0);
    check("rst_class_valid", 64'(class_valid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check_frame("rst_frame", frame_out, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 3; r++) run_row(rows[r]);

    // Flush concurrent with the 20th accept of a fresh fill.
    do_flush();
    check("flush_s_ready", 64'(s_ready), 64'd1);
    check("flush_frame_valid", 64'(frame_valid), 64'd0);
    check("flush_keeps_class", 64'(class_out), 64'h5A);
    class_in = 8'h77;
    cur_cls  = 8'h77;
    for (int i = 0; i < 19; i++) send(W'(100 + i), 1'b0, 1'b0);
    send(W'(119), 1'b0, 1'b1);
    check("flush_accept_frame_valid", 64'(frame_valid), 64'd0);
    check("flush_accept_s_ready", 64'(s_ready), 64'd1);
    check("flush_keeps_count", 64'(frame_count), 64'd3);
    for (int i = 0; i < 31; i++) send(W'(200 + i), 1'b0, 1'b0);
    check("flush_31_frame_valid", 64'(frame_valid), 64'd0);
    send(W'(231), 1'b0, 1'b0);
    check("flush_32_frame_valid", 64'(frame_valid), 64'd1);
    check("flush_sample0", 64'(frame_out[W-1:0]), 64'd200);
    s_valid = 1'b0;
    wait_done();
    check("flush_frame_count", 64'(frame_count), 64'd4);

    // Asynchronous reset in the middle of SETTLE.
    for (int i = 0; i < HOP; i++) send(W'(300 + i), 1'b0, 1'b0);
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_class_out", 64'(class_out), 64'd0);
    check("arst_frame_count", 64'(frame_count), 64'd0);
    check("arst_s_ready", 64'(s_ready), 64'd1);
    check("arst_frame_valid", 64'(frame_valid), 64'd0);
    check_frame("arst_frame", frame_out, '0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);

    run_row(rows[3]);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
